mpu_stream_service: RTL and testbench

Parametrised next-generation MPU data service. It bridges the external streaming port and the MPU data-memory port in either direction:
- Store: extern → buffer → data memory.
- Load: data memory → buffer → extern.

A 3-word header (CMD/STRIDE, LENGTH, BASE) configures each transfer. Valid/ready backpressure on both sides, a programmable occupancy watermark notify, and error detection are new relative to the previous generation.

---
 rtl/mpu_stream_service_pkg.sv | 23 ++
 rtl/mpu_stream_service_ring_buff_ctrl_cnt.sv | 51 +++++
 rtl/mpu_stream_service.sv | 219 +++++++++++++++++++++
 tb/tb_mpu_stream_service.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_stream_service_pkg.sv
// Shared types and constants for the MPU stream service: FSM state encoding
// and header layout helpers.
package pkg_mpu;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LEN,
        HDR_BASE,
        ST_REQ,
        ST_RUN,
        LD_REQ,
        LD_RUN,
        DRAIN
    } fsm_mpu_stream_t;

    localparam int HDR_WORDS = 3;

    // Direction flag sits in the MSB of header word 0.
    function automatic int dir_bit_idx(input int width_data);
        return width_data - 1;
    endfunction

endpackage

// File: rtl/mpu_stream_service_ring_buff_ctrl_cnt.sv
// Ring-buffer pointer/occupancy controller. Storage lives in the parent; this
// block only tracks addresses, count and registered full/empty flags.
module ring_buff_ctrl_cnt #(
    parameter int NUM_ENTRY = 128
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         I_We,
    input  logic                         I_Re,
    output logic [$clog2(NUM_ENTRY)-1:0] O_WAddr,
    output logic [$clog2(NUM_ENTRY)-1:0] O_RAddr,
    output logic                         O_Full,
    output logic                         O_Empty,
    output logic [$clog2(NUM_ENTRY):0]   O_Num
);

    localparam int ADDR_W = $clog2(NUM_ENTRY);

    logic [ADDR_W-1:0] waddr_reg, raddr_reg;
    logic [ADDR_W:0]   num_reg, num_next;
    logic              full_reg, empty_reg;
    logic              we_ok, re_ok;

    // A write is refused only when full, regardless of a same-cycle read.
    assign we_ok    = I_We & ~full_reg;
    assign re_ok    = I_Re & ~empty_reg;
    assign num_next = num_reg + (ADDR_W+1)'(we_ok) - (ADDR_W+1)'(re_ok);

    always_ff @(posedge clock) begin
        if (reset) begin
            waddr_reg <= '0;
            raddr_reg <= '0;
            num_reg   <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            if (we_ok) waddr_reg <= waddr_reg + 1'b1;
            if (re_ok) raddr_reg <= raddr_reg + 1'b1;
            num_reg   <= num_next;
            full_reg  <= (num_next == (ADDR_W+1)'(NUM_ENTRY));
            empty_reg <= (num_next == '0);
        end
    end

    assign O_WAddr = waddr_reg;
    assign O_RAddr = raddr_reg;
    assign O_Full  = full_reg;
    assign O_Empty = empty_reg;
    assign O_Num   = num_reg;

endmodule

// File: rtl/mpu_stream_service.sv
// MPU data service: header-configured store (extern -> data memory) or load
// (data memory -> extern) transfer through a shared ring buffer.
module mpu_stream_service
    import pkg_mpu::*;
#(
    parameter int WIDTH_DATA  = 32,
    parameter int BUFF_SIZE   = 128,
    parameter int WIDTH_LEN   = 16,
    parameter int NOTIFY_MARK = BUFF_SIZE / 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Req,
    input  logic [WIDTH_DATA-1:0] I_Data,
    output logic                  O_Rdy,
    output logic                  O_Req,
    output logic [WIDTH_DATA-1:0] O_Data,
    input  logic                  I_Rdy,
    output logic                  O_St_Req,
    input  logic                  I_St_Grant,
    output logic                  O_St_Valid,
    output logic [WIDTH_DATA-1:0] O_St_Data,
    input  logic                  I_St_Rdy,
    output logic                  O_St_Rls,
    output logic                  O_Ld_Req,
    input  logic                  I_Ld_Grant,
    input  logic                  I_Ld_Valid,
    input  logic [WIDTH_DATA-1:0] I_Ld_Data,
    output logic                  O_Ld_Rdy,
    input  logic                  I_Ld_Rls,
    output logic [WIDTH_DATA-2:0] O_Stride,
    output logic [WIDTH_LEN-1:0]  O_Length,
    output logic [WIDTH_DATA-1:0] O_Base,
    output logic                  O_Busy,
    output logic                  O_Notify,
    output logic                  O_Err
);

    localparam int ADDR_W                 = $clog2(BUFF_SIZE);
    localparam int DIR_IDX                = dir_bit_idx(WIDTH_DATA);
    localparam logic [ADDR_W:0] MARK      = (ADDR_W+1)'(NOTIFY_MARK);
    localparam logic [WIDTH_LEN-1:0] ONE  = WIDTH_LEN'(1);

    fsm_mpu_stream_t state_reg, state_next;

    logic                  dir_reg;
    logic [WIDTH_DATA-2:0] stride_reg;
    logic [WIDTH_LEN-1:0]  len_reg;
    logic [WIDTH_DATA-1:0] base_reg;
    logic [WIDTH_LEN-1:0]  cnt_in_reg, cnt_out_reg, cnt_in_after;
    logic                  err_reg, err_next;
    logic                  hdr0_acc, hdr1_acc, hdr2_acc;
    logic                  ext_rdy, st_req, st_valid, st_rls;
    logic                  ld_req, ld_rdy, ld_out_valid;
    logic                  push, pop, in_left;

    logic [WIDTH_DATA-1:0] buf_mem [BUFF_SIZE];
    logic [WIDTH_DATA-1:0] wr_data, head_data;
    logic [ADDR_W-1:0]     waddr, raddr;
    logic                  buf_full, buf_empty;
    logic [ADDR_W:0]       buf_num, buf_num_next;

    assign in_left      = (cnt_in_reg < len_reg);
    assign cnt_in_after = cnt_in_reg + (push ? ONE : '0);

    always_comb begin
        state_next   = state_reg;
        err_next     = 1'b0;
        hdr0_acc     = 1'b0;
        hdr1_acc     = 1'b0;
        hdr2_acc     = 1'b0;
        ext_rdy      = 1'b0;
        st_req       = 1'b0;
        st_valid     = 1'b0;
        st_rls       = 1'b0;
        ld_req       = 1'b0;
        ld_rdy       = 1'b0;
        ld_out_valid = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                ext_rdy = 1'b1;
                if (I_Req) begin
                    hdr0_acc   = 1'b1;
                    state_next = HDR_LEN;
                end
            end
            HDR_LEN: begin
                ext_rdy = 1'b1;
                if (I_Req) begin
                    hdr1_acc = 1'b1;
                    if (I_Data[WIDTH_LEN-1:0] == '0) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = HDR_BASE;
                    end
                end
            end
            HDR_BASE: begin
                ext_rdy = 1'b1;
                if (I_Req) begin
                    hdr2_acc   = 1'b1;
                    state_next = dir_reg ? LD_REQ : ST_REQ;
                end
            end
            ST_REQ: begin
                // Words are buffered ahead of the memory grant.
                st_req  = 1'b1;
                ext_rdy = ~buf_full & in_left;
                push    = I_Req & ext_rdy;
                if (I_St_Grant) state_next = ST_RUN;
            end
            ST_RUN: begin
                st_req   = 1'b1;
                ext_rdy  = ~buf_full & in_left;
                push     = I_Req & ext_rdy;
                st_valid = ~buf_empty;
                pop      = st_valid & I_St_Rdy;
                if (pop && (cnt_out_reg + ONE == len_reg)) begin
                    st_rls     = 1'b1;
                    state_next = IDLE;
                end
            end
            LD_REQ: begin
                ld_req = 1'b1;
                if (I_Ld_Grant) state_next = LD_RUN;
            end
            LD_RUN: begin
                ld_req       = 1'b1;
                ld_rdy       = ~buf_full & in_left;
                push         = I_Ld_Valid & ld_rdy;
                ld_out_valid = ~buf_empty;
                pop          = ld_out_valid & I_Rdy;
                // A short stream is flagged but whatever arrived is still delivered.
                if (I_Ld_Rls) begin
                    state_next = DRAIN;
                    err_next   = (cnt_in_after != len_reg);
                end
            end
            DRAIN: begin
                ld_out_valid = ~buf_empty;
                pop          = ld_out_valid & I_Rdy;
                if (buf_empty) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            dir_reg     <= 1'b0;
            stride_reg  <= '0;
            len_reg     <= '0;
            base_reg    <= '0;
            cnt_in_reg  <= '0;
            cnt_out_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (hdr0_acc) begin
                dir_reg     <= I_Data[DIR_IDX];
                stride_reg  <= I_Data[WIDTH_DATA-2:0];
                cnt_in_reg  <= '0;
                cnt_out_reg <= '0;
            end else begin
                if (push) cnt_in_reg  <= cnt_in_reg + ONE;
                if (pop)  cnt_out_reg <= cnt_out_reg + ONE;
            end
            if (hdr1_acc) len_reg  <= I_Data[WIDTH_LEN-1:0];
            if (hdr2_acc) base_reg <= I_Data;
        end
    end

    assign wr_data = (state_reg == LD_RUN) ? I_Ld_Data : I_Data;

    always_ff @(posedge clock) begin
        if (push) buf_mem[waddr] <= wr_data;
    end

    assign head_data = buf_mem[raddr];

    ring_buff_ctrl_cnt #(
        .NUM_ENTRY (BUFF_SIZE)
    ) u_ring (
        .clock   (clock),
        .reset   (reset),
        .I_We    (push),
        .I_Re    (pop),
        .O_WAddr (waddr),
        .O_RAddr (raddr),
        .O_Full  (buf_full),
        .O_Empty (buf_empty),
        .O_Num   (buf_num)
    );

    assign buf_num_next = buf_num + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

    // Data outputs are gated so stale storage never shows while idle.
    assign O_Rdy      = ext_rdy;
    assign O_Req      = ld_out_valid;
    assign O_Data     = ld_out_valid ? head_data : '0;
    assign O_St_Req   = st_req;
    assign O_St_Valid = st_valid;
    assign O_St_Data  = st_valid ? head_data : '0;
    assign O_St_Rls   = st_rls;
    assign O_Ld_Req   = ld_req;
    assign O_Ld_Rdy   = ld_rdy;
    assign O_Stride   = stride_reg;
    assign O_Length   = len_reg;
    assign O_Base     = base_reg;
    assign O_Busy     = (state_reg != IDLE);
    assign O_Notify   = (buf_num < MARK) && (buf_num_next >= MARK);
    assign O_Err      = err_reg;

endmodule

// File: tb/tb_mpu_stream_service.sv
// Randomized self-checking bench: queue-based transfer model drives and checks
// store, load, zero-length, short-load and reset-abort scenarios.
module tb_mpu_stream_service;

    localparam int WD   = 32;
    localparam int BS   = 8;
    localparam int WL   = 16;
    localparam int MARK = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          I_Req = 1'b0;
    logic [WD-1:0] I_Data = '0;
    logic          O_Rdy;
    logic          O_Req;
    logic [WD-1:0] O_Data;
    logic          I_Rdy = 1'b0;
    logic          O_St_Req;
    logic          I_St_Grant = 1'b0;
    logic          O_St_Valid;
    logic [WD-1:0] O_St_Data;
    logic          I_St_Rdy = 1'b0;
    logic          O_St_Rls;
    logic          O_Ld_Req;
    logic          I_Ld_Grant = 1'b0;
    logic          I_Ld_Valid = 1'b0;
    logic [WD-1:0] I_Ld_Data = '0;
    logic          O_Ld_Rdy;
    logic          I_Ld_Rls = 1'b0;
    logic [WD-2:0] O_Stride;
    logic [WL-1:0] O_Length;
    logic [WD-1:0] O_Base;
    logic          O_Busy;
    logic          O_Notify;
    logic          O_Err;

    int n_pass  = 0;
    int n_total = 0;

    mpu_stream_service #(
        .WIDTH_DATA  (WD),
        .BUFF_SIZE   (BS),
        .WIDTH_LEN   (WL),
        .NOTIFY_MARK (MARK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .I_Req      (I_Req),
        .I_Data     (I_Data),
        .O_Rdy      (O_Rdy),
        .O_Req      (O_Req),
        .O_Data     (O_Data),
        .I_Rdy      (I_Rdy),
        .O_St_Req   (O_St_Req),
        .I_St_Grant (I_St_Grant),
        .O_St_Valid (O_St_Valid),
        .O_St_Data  (O_St_Data),
        .I_St_Rdy   (I_St_Rdy),
        .O_St_Rls   (O_St_Rls),
        .O_Ld_Req   (O_Ld_Req),
        .I_Ld_Grant (I_Ld_Grant),
        .I_Ld_Valid (I_Ld_Valid),
        .I_Ld_Data  (I_Ld_Data),
        .O_Ld_Rdy   (O_Ld_Rdy),
        .I_Ld_Rls   (I_Ld_Rls),
        .O_Stride   (O_Stride),
        .O_Length   (O_Length),
        .O_Base     (O_Base),
        .O_Busy     (O_Busy),
        .O_Notify   (O_Notify),
        .O_Err      (O_Err)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_rdy"},    O_Rdy, 1);
        check_val({tag, "_req"},    O_Req, 0);
        check_val({tag, "_data"},   O_Data, 0);
        check_val({tag, "_streq"},  O_St_Req, 0);
        check_val({tag, "_stvld"},  O_St_Valid, 0);
        check_val({tag, "_stdata"}, O_St_Data, 0);
        check_val({tag, "_strls"},  O_St_Rls, 0);
        check_val({tag, "_ldreq"},  O_Ld_Req, 0);
        check_val({tag, "_ldrdy"},  O_Ld_Rdy, 0);
        check_val({tag, "_stride"}, O_Stride, 0);
        check_val({tag, "_len"},    O_Length, 0);
        check_val({tag, "_base"},   O_Base, 0);
        check_val({tag, "_busy"},   O_Busy, 0);
        check_val({tag, "_notify"}, O_Notify, 0);
        check_val({tag, "_err"},    O_Err, 0);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"},  O_Busy, 0);
        check_val({tag, "_rdy"},   O_Rdy, 1);
        check_val({tag, "_streq"}, O_St_Req, 0);
        check_val({tag, "_ldreq"}, O_Ld_Req, 0);
        check_val({tag, "_err"},   O_Err, 0);
        check_val({tag, "_stvld"}, O_St_Valid, 0);
        check_val({tag, "_req"},   O_Req, 0);
    endtask

    task automatic send_word(input logic [WD-1:0] w, input bit exp_busy);
        I_Req  = 1'b1;
        I_Data = w;
        @(negedge clock);
        check_val("hdr_rdy", O_Rdy, 1);
        check_val("hdr_busy", O_Busy, exp_busy);
        next_cycle();
        I_Req = 1'b0;
    endtask

    task automatic run_store(input int n, input int grant_dly, input int rdy_pct, input int req_pct);
        logic [WD-1:0] src[$];
        logic [WD-1:0] q[$];
        logic [WD-2:0] stride;
        logic [WD-1:0] base;
        int  sent = 0, popped = 0, cur, nxt, cyc;
        bit  run = 0, done = 0, push, pop, exp_rdy, exp_valid, exp_rls;
        stride = WD'($urandom) >> 1;
        base   = $urandom;
        for (int i = 0; i < n; i++) src.push_back($urandom);
        send_word({1'b0, stride}, 0);
        send_word(WD'(n), 1);
        send_word(base, 1);
        for (cyc = 0; cyc < 4000 && !done; cyc++) begin
            I_Req = ($urandom_range(99) < req_pct);
            if (sent < n) I_Data = src[sent];
            else          I_Data = $urandom;
            I_St_Grant = (cyc >= grant_dly);
            I_St_Rdy   = ($urandom_range(99) < rdy_pct);
            @(negedge clock);
            if (cyc == 0) begin
                check_val("st_stride", O_Stride, stride);
                check_val("st_len", O_Length, n);
                check_val("st_base", O_Base, base);
            end
            cur       = q.size();
            exp_rdy   = (cur < BS) && (sent < n);
            exp_valid = run && (cur > 0);
            push      = I_Req && exp_rdy;
            pop       = exp_valid && I_St_Rdy;
            exp_rls   = pop && (popped + 1 == n);
            nxt       = cur + int'(push) - int'(pop);
            check_val("st_rdy", O_Rdy, exp_rdy);
            check_val("st_req", O_St_Req, 1);
            check_val("st_valid", O_St_Valid, exp_valid);
            if (exp_valid) check_val("st_data", O_St_Data, q[0]);
            else           check_val("st_data_idle", O_St_Data, 0);
            check_val("st_rls", O_St_Rls, exp_rls);
            check_val("st_notify", O_Notify, (cur < MARK) && (nxt >= MARK));
            check_val("st_busy", O_Busy, 1);
            check_val("st_err", O_Err, 0);
            check_val("st_ldreq", O_Ld_Req, 0);
            if (pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (push) begin
                q.push_back(src[sent]);
                sent++;
            end
            if (exp_rls) done = 1;
            if (I_St_Grant) run = 1;
            next_cycle();
        end
        if (!done) check_val("st_timeout", 0, 1);
        I_Req      = 1'b0;
        I_St_Grant = 1'b0;
        I_St_Rdy   = 1'b0;
        @(negedge clock);
        check_idle("st_end");
        next_cycle();
        $display("store n=%0d sent=%0d popped=%0d cycles=%0d", n, sent, popped, cyc);
    endtask

    task automatic run_load(input int n, input int limit, input int grant_dly,
                            input int rdy_hold, input int rdy_pct, input int vld_pct);
        logic [WD-1:0] src[$];
        logic [WD-1:0] q[$];
        logic [WD-2:0] stride;
        logic [WD-1:0] base;
        int  sent = 0, got = 0, cur, nxt, cyc;
        bit  run = 0, drain = 0, done = 0, err_exp = 0;
        bit  push, pop, exp_ldrdy, exp_req;
        stride = WD'($urandom) >> 1;
        base   = $urandom;
        for (int i = 0; i < limit; i++) src.push_back($urandom);
        send_word({1'b1, stride}, 0);
        send_word(WD'(n), 1);
        send_word(base, 1);
        for (cyc = 0; cyc < 4000 && !done; cyc++) begin
            I_Ld_Grant = (cyc >= grant_dly);
            I_Ld_Rls   = run && (sent == limit) && ($urandom_range(3) == 0);
            I_Ld_Valid = !I_Ld_Rls && (sent < limit) && ($urandom_range(99) < vld_pct);
            if (sent < limit) I_Ld_Data = src[sent];
            else              I_Ld_Data = $urandom;
            I_Rdy = (cyc >= rdy_hold) && ($urandom_range(99) < rdy_pct);
            @(negedge clock);
            if (cyc == 0) begin
                check_val("ld_stride", O_Stride, stride);
                check_val("ld_len", O_Length, n);
                check_val("ld_base", O_Base, base);
            end
            cur       = q.size();
            exp_ldrdy = run && (cur < BS) && (sent < n);
            exp_req   = (run || drain) && (cur > 0);
            push      = I_Ld_Valid && exp_ldrdy;
            pop       = exp_req && I_Rdy;
            nxt       = cur + int'(push) - int'(pop);
            check_val("ld_req", O_Ld_Req, !drain);
            check_val("ld_rdy", O_Ld_Rdy, exp_ldrdy);
            check_val("ld_oreq", O_Req, exp_req);
            if (exp_req) check_val("ld_data", O_Data, q[0]);
            else         check_val("ld_data_idle", O_Data, 0);
            check_val("ld_err", O_Err, err_exp);
            check_val("ld_busy", O_Busy, 1);
            check_val("ld_ext_rdy", O_Rdy, 0);
            check_val("ld_streq", O_St_Req, 0);
            check_val("ld_notify", O_Notify, (cur < MARK) && (nxt >= MARK));
            err_exp = 0;
            if (drain && cur == 0) done = 1;
            if (pop) begin
                void'(q.pop_front());
                got++;
            end
            if (push) begin
                q.push_back(src[sent]);
                sent++;
            end
            if (run && I_Ld_Rls) begin
                run     = 0;
                drain   = 1;
                err_exp = (sent != n);
            end
            if (!run && !drain && I_Ld_Grant) run = 1;
            next_cycle();
        end
        if (!done) check_val("ld_timeout", 0, 1);
        I_Ld_Grant = 1'b0;
        I_Ld_Valid = 1'b0;
        I_Ld_Rls   = 1'b0;
        I_Rdy      = 1'b0;
        @(negedge clock);
        check_idle("ld_end");
        next_cycle();
        $display("load n=%0d received=%0d delivered=%0d cycles=%0d", n, sent, got, cyc);
    endtask

    task automatic zero_len();
        send_word({1'b0, 31'h5}, 0);
        send_word('0, 1);
        @(negedge clock);
        check_val("zl_err", O_Err, 1);
        check_val("zl_busy", O_Busy, 0);
        check_val("zl_rdy", O_Rdy, 1);
        check_val("zl_streq", O_St_Req, 0);
        check_val("zl_ldreq", O_Ld_Req, 0);
        next_cycle();
        @(negedge clock);
        check_val("zl_err_clr", O_Err, 0);
        next_cycle();
        $display("zero-length header rejected");
    endtask

    task automatic reset_mid_store();
        int pops = 0;
        send_word({1'b0, 31'h3}, 0);
        send_word(WD'(5), 1);
        send_word(32'h200, 1);
        I_St_Grant = 1'b1;
        I_St_Rdy   = 1'b1;
        for (int cyc = 0; cyc < 200 && pops < 2; cyc++) begin
            I_Req  = 1'b1;
            I_Data = $urandom;
            @(negedge clock);
            if (O_St_Valid) pops++;
            next_cycle();
        end
        if (pops < 2) check_val("rst_timeout", 0, 1);
        I_Req      = 1'b0;
        I_St_Grant = 1'b0;
        I_St_Rdy   = 1'b0;
        reset      = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check_reset_state("rst_mid");
        next_cycle();
        @(negedge clock);
        check_val("rst_mid_err2", O_Err, 0);
        check_val("rst_mid_rls2", O_St_Rls, 0);
        next_cycle();
        $display("reset during store after %0d words", pops);
    endtask

    initial begin
        int n, lim;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_state("por");
        next_cycle();

        run_store(4, 10, 100, 100);
        run_load(10, 10, 0, 30, 100, 100);
        zero_len();
        run_load(6, 3, 2, 0, 70, 100);
        run_store(6, 15, 100, 100);
        reset_mid_store();
        run_load(7, 7, 1, 0, 60, 80);

        for (int t = 0; t < 14; t++) begin
            n = $urandom_range(1, 20);
            if ($urandom_range(1) == 1) begin
                lim = ($urandom_range(3) == 0) ? $urandom_range(0, n - 1) : n;
                run_load(n, lim, $urandom_range(0, 6), $urandom_range(0, 15),
                         $urandom_range(30, 100), $urandom_range(30, 100));
            end else begin
                run_store(n, $urandom_range(0, 15), $urandom_range(30, 100),
                          $urandom_range(30, 100));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
